// File: rtl/fault_sim_sequencer.sv
// rtl/fault_sim_sequencer.sv - fault-simulation vector sequencer with delayed response sampling
// Applies NUM_VECTORS binary/LFSR vectors, samples the detector RESP_LATENCY cycles later, summarises faults.
module fault_sim_sequencer #(
    parameter int VEC_WIDTH    = 8,
    parameter int NUM_VECTORS  = 16,
    parameter int RESP_LATENCY = 1,
    parameter int CNT_WIDTH    = 9
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode,
    input  logic [VEC_WIDTH-1:0] seed,
    output logic [VEC_WIDTH-1:0] test_vector,
    output logic                 vector_valid,
    input  logic                 fault_detected,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] fault_count,
    output logic [CNT_WIDTH-1:0] first_fail_idx,
    output logic                 first_fail_valid
);
    localparam int WAIT_LAST = (RESP_LATENCY > 1) ? RESP_LATENCY - 2 : 0;
    localparam int WAIT_W    = (WAIT_LAST > 0) ? $clog2(WAIT_LAST + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_VECTORS - 1);
    localparam logic [VEC_WIDTH-1:0] VEC_ONE  = VEC_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_WAIT, S_SAMPLE} state_t;

    state_t                 state_q;
    logic                   mode_q;
    logic [VEC_WIDTH-1:0]   vec_q;
    logic [CNT_WIDTH-1:0]   idx_q;
    logic [WAIT_W-1:0]      wait_q;
    logic                   vv_q;
    logic                   busy_q;
    logic                   done_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   ffi_q;
    logic                   ffv_q;

    // Taps x^8+x^6+x^5+x^4+1; a nonzero state never shifts into all-zero.
    function automatic logic [VEC_WIDTH-1:0] advance(input logic lfsr, input logic [VEC_WIDTH-1:0] v);
        if (lfsr) begin
            return {v[VEC_WIDTH-2:0], v[VEC_WIDTH-1] ^ v[VEC_WIDTH-3] ^ v[VEC_WIDTH-4] ^ v[VEC_WIDTH-5]};
        end
        return v + VEC_ONE;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            vec_q   <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            vv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
        end else begin
            vv_q <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            mode_q  <= mode;
                            vec_q   <= !mode ? '0 : ((seed == '0) ? VEC_ONE : seed);
                            idx_q   <= '0;
                            cnt_q   <= '0;
                            ffi_q   <= '0;
                            ffv_q   <= 1'b0;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            vv_q    <= 1'b1;
                            state_q <= S_APPLY;
                        end
                    end
                    S_APPLY: begin
                        if (RESP_LATENCY > 1) begin
                            wait_q  <= '0;
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_SAMPLE;
                        end
                    end
                    S_WAIT: begin
                        if (wait_q == WAIT_W'(WAIT_LAST)) begin
                            state_q <= S_SAMPLE;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        if (fault_detected) begin
                            if (cnt_q != '1) begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                            if (!ffv_q) begin
                                ffi_q <= idx_q;
                                ffv_q <= 1'b1;
                            end
                        end
                        if (idx_q == LAST_IDX) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            vec_q   <= advance(mode_q, vec_q);
                            idx_q   <= idx_q + 1'b1;
                            vv_q    <= 1'b1;
                            state_q <= S_APPLY;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign test_vector      = vec_q;
    assign vector_valid     = vv_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign fault_count      = cnt_q;
    assign first_fail_idx   = ffi_q;
    assign first_fail_valid = ffv_q;
endmodule

// File: tb/tb_fault_sim_sequencer.sv
// tb/tb_fault_sim_sequencer.sv - scoreboard bench for fault_sim_sequencer
// Two instances (latency 1 / 9-bit counts, latency 3 / saturating 4-bit counts) share the run inputs.
module tb_fault_sim_sequencer;
    localparam int N = 16, L0 = 1, L1 = 3, CW0 = 9, CW1 = 4;

    logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, mode = 1'b0;
    logic abort0 = 1'b0, abort1 = 1'b0;
    logic [7:0] seed = 8'h00, mask = 8'h00;
    logic [7:0] tv0, tv1;
    logic vv0, vv1, busy0, busy1, done0, done1, ffv0, ffv1;
    logic [CW0-1:0] fc0, ffi0;
    logic [CW1-1:0] fc1, ffi1;
    logic fd0 = 1'b0, fd1 = 1'b0, p1 = 1'b0, p2 = 1'b0;
    logic done0_prev = 1'b0, done1_prev = 1'b0;
    int cyc = 0, checks = 0, failures = 0;
    int exp_cnt, exp_fi;
    bit exp_fv;
    logic [7:0] exp_last;

    typedef struct {logic [7:0] vec; int cyc;} vexp_t;
    typedef struct {int cnt; int idx; bit valid; int cyc;} rexp_t;
    vexp_t vq0[$], vq1[$];
    rexp_t rq0[$], rq1[$];

    fault_sim_sequencer #(.VEC_WIDTH(8), .NUM_VECTORS(N), .RESP_LATENCY(L0), .CNT_WIDTH(CW0)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort0), .mode(mode), .seed(seed),
        .test_vector(tv0), .vector_valid(vv0), .fault_detected(fd0), .busy(busy0), .done(done0),
        .fault_count(fc0), .first_fail_idx(ffi0), .first_fail_valid(ffv0));

    fault_sim_sequencer #(.VEC_WIDTH(8), .NUM_VECTORS(N), .RESP_LATENCY(L1), .CNT_WIDTH(CW1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort1), .mode(mode), .seed(seed),
        .test_vector(tv1), .vector_valid(vv1), .fault_detected(fd1), .busy(busy1), .done(done1),
        .fault_count(fc1), .first_fail_idx(ffi1), .first_fail_valid(ffv1));

    always #5 clk = ~clk;

    // Detectors: fault when any masked vector bit is set, delivered with 1 and 3 register stages.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        fd0 <= |(tv0 & mask);
        p1  <= |(tv1 & mask);
        p2  <= p1;
        fd1 <= p2;
    end

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_vv(input int inst, input logic [7:0] tv, input int c);
        vexp_t e;
        checks++;
        if ((inst == 0 && vq0.size() == 0) || (inst == 1 && vq1.size() == 0)) begin
            failures++;
            $display("FAIL vv_unexpected_%0d actual=%02h@%0d required=none", inst, tv, c);
        end else begin
            if (inst == 0) e = vq0.pop_front(); else e = vq1.pop_front();
            if (tv !== e.vec || c != e.cyc) begin
                failures++;
                $display("FAIL vector_%0d actual=%02h@%0d required=%02h@%0d", inst, tv, c, e.vec, e.cyc);
            end
        end
    endtask

    task automatic check_done(input int inst, input int fc, input int ffi, input bit ffv, input bit bsy, input int c);
        rexp_t e;
        checks++;
        if ((inst == 0 && rq0.size() == 0) || (inst == 1 && rq1.size() == 0)) begin
            failures++;
            $display("FAIL done_unexpected_%0d actual=cnt%0d@%0d required=none", inst, fc, c);
        end else begin
            if (inst == 0) e = rq0.pop_front(); else e = rq1.pop_front();
            if (fc != e.cnt || ffi != e.idx || ffv != e.valid || c != e.cyc || bsy) begin
                failures++;
                $display("FAIL result_%0d actual=cnt%0d idx%0d v%0d @%0d busy%0d required=cnt%0d idx%0d v%0d @%0d busy0",
                         inst, fc, ffi, ffv, c, bsy, e.cnt, e.idx, e.valid, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && vv0) check_vv(0, tv0, cyc);
        if (reset_n && done0 && !done0_prev) check_done(0, int'(fc0), int'(ffi0), ffv0, busy0, cyc);
        done0_prev <= done0;
    end

    always @(negedge clk) begin
        if (reset_n && vv1) check_vv(1, tv1, cyc);
        if (reset_n && done1 && !done1_prev) check_done(1, int'(fc1), int'(ffi1), ffv1, busy1, cyc);
        done1_prev <= done1;
    end

    function automatic logic [7:0] ref_next(input bit m, input logic [7:0] v);
        return m ? {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]} : v + 8'd1;
    endfunction

    // n0/n1 vectors expected on each instance; with complete=0 only the first max(n0,n1)-1 are sampled.
    task automatic expect_run(input bit m, input logic [7:0] sd, input int a, input int n0, input int n1, input bit complete);
        logic [7:0] v;
        int cnt, fi, ns, nmax;
        bit fv;
        v = m ? ((sd == 8'h00) ? 8'h01 : sd) : 8'h00;
        cnt = 0; fi = 0; fv = 0;
        nmax = (n0 > n1) ? n0 : n1;
        ns = complete ? N : nmax - 1;
        for (int k = 0; k < nmax; k++) begin
            if (k < n0) vq0.push_back('{v, a + k * (L0 + 1)});
            if (k < n1) vq1.push_back('{v, a + k * (L1 + 1)});
            if (k < ns && (v & mask) != 8'h00) begin
                cnt++;
                if (!fv) begin fi = k; fv = 1; end
            end
            exp_last = v;
            v = ref_next(m, v);
        end
        exp_cnt = cnt; exp_fi = fi; exp_fv = fv;
        if (complete) begin
            rq0.push_back('{(cnt > 511) ? 511 : cnt, fi, fv, a + N * (L0 + 1)});
            rq1.push_back('{(cnt > 15) ? 15 : cnt, fi, fv, a + N * (L1 + 1)});
        end
    endtask

    task automatic do_start(input bit m, input logic [7:0] sd, input logic [7:0] mk, output int a);
        mask = mk; mode = m; seed = sd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = cyc;
    endtask

    task automatic run_full(input bit m, input logic [7:0] sd, input logic [7:0] mk, input bit disturb);
        int a, t;
        do_start(m, sd, mk, a);
        expect_run(m, sd, a, N, N, 1);
        t = 0;
        while ((vq0.size() + vq1.size() + rq0.size() + rq1.size()) != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
            if (disturb) begin
                start = busy0 && busy1 && ($urandom_range(0, 3) == 0);
                mode  = 1'($urandom_range(0, 1));
                seed  = 8'($urandom);
            end
        end
        start = 1'b0;
        checks++;
        if (t >= 300) begin
            failures++;
            $display("FAIL run_timeout actual=%0d required=<300", t);
            vq0.delete(); vq1.delete(); rq0.delete(); rq1.delete();
        end
        check_eq("idle_hold_tv0", int'(tv0), int'(exp_last));
        check_eq("idle_hold_tv1", int'(tv1), int'(exp_last));
    endtask

    task automatic abort_at(input int inst, input int target);
        int t;
        t = 0;
        while (cyc < target && t < 200) begin @(posedge clk); #1; t++; end
        if (inst == 0) abort0 = 1'b1; else abort1 = 1'b1;
        @(posedge clk); #1;
        abort0 = 1'b0; abort1 = 1'b0;
        if (inst == 0) begin
            check_eq("abort_state0", int'({busy0, vv0, done0}), 0);
            check_eq("abort_cnt0", int'(fc0), exp_cnt);
            check_eq("abort_first0", int'({ffv0, ffi0}), int'({exp_fv, 9'(exp_fi)}));
        end else begin
            check_eq("abort_state1", int'({busy1, vv1, done1}), 0);
            check_eq("abort_cnt1", int'(fc1), exp_cnt);
            check_eq("abort_first1", int'({ffv1, ffi1}), int'({exp_fv, 4'(exp_fi)}));
        end
    endtask

    initial begin
        int a, t;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outs0", int'({tv0, vv0, busy0, done0, fc0, ffi0, ffv0}), 0);
        check_eq("reset_outs1", int'({tv1, vv1, busy1, done1, fc1, ffi1, ffv1}), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_full(0, 8'h5A, 8'h08, 0);
        check_eq("bin_cnt0", int'(fc0), 8);
        check_eq("bin_first0", int'(ffi0), 8);
        check_eq("bin_first_valid1", int'(ffv1), 1);
        run_full(1, 8'h01, 8'h08, 0);
        check_eq("lfsr_first0", int'(ffi0), 3);
        run_full(1, 8'h00, 8'h08, 0);
        run_full(0, 8'h00, 8'h00, 0);
        check_eq("nofault_cnt1", int'(fc1), 0);
        check_eq("nofault_valid1", int'(ffv1), 0);
        run_full(1, 8'hA5, 8'hFF, 0);
        check_eq("allfault_cnt0", int'(fc0), 16);
        check_eq("sat_cnt1", int'(fc1), 15);

        do_start(1, 8'h01, 8'h0A, a);
        expect_run(1, 8'h01, a, 7, 7, 0);
        fork
            abort_at(0, a + 6 * (L0 + 1));
            abort_at(1, a + 6 * (L1 + 1));
        join
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_vq_left", vq0.size() + vq1.size(), 0);
        check_eq("abort_no_done", int'({done0, done1}), 0);
        run_full(1, 8'h01, 8'h0A, 0);

        start = 1'b1; abort0 = 1'b1; abort1 = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("start_abort_idle", int'({busy0, busy1, vv0, vv1}), 0);

        do_start(0, 8'h00, 8'h08, a);
        expect_run(0, 8'h00, a, 5, 3, 0);
        t = 0;
        while (cyc < a + 10 && t < 100) begin @(posedge clk); #1; t++; end
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_async_outs0", int'({tv0, vv0, busy0, done0, fc0, ffi0, ffv0}), 0);
        check_eq("rst_async_outs1", int'({tv1, vv1, busy1, done1, fc1, ffi1, ffv1}), 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("rst_quiet", int'({busy0, busy1, done0, done1}), 0);
        check_eq("rst_vq_left", vq0.size() + vq1.size(), 0);
        run_full(0, 8'h00, 8'h08, 0);

        for (int r = 0; r < 6; r++) begin
            run_full(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1);
        end

        repeat (5) @(posedge clk);
        #1;
        check_eq("final_queues", vq0.size() + vq1.size() + rq0.size() + rq1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fault_sim_sequencer.md
Name: fault_sim_sequencer

Overview:
Sequences a fault-simulation run against a registered fault-detection block: generates NUM_VECTORS test vectors (binary count or 8-bit LFSR), applies one per vector period, samples the detector's fault_detected flag a fixed latency later, and accumulates results. Sits between the BIST/scan top-level control and the fault-model datapath. Exposes a start/busy/done handshake and a result summary.

Parameters:
VEC_WIDTH, 8, test vector width; LFSR mode is legal only at 8.
NUM_VECTORS, 16, vectors per run; range 1..2^VEC_WIDTH.
RESP_LATENCY, 1, cycles from vector-apply cycle to the cycle fault_detected is valid; must be >=1.
CNT_WIDTH, 9, width of fault_count and first_fail_idx; must satisfy 2^CNT_WIDTH > NUM_VECTORS-1.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  run request; accepted only in IDLE
abort  input  1  terminate current run
mode  input  1  0 = binary counter, 1 = LFSR; latched at start
seed  input  VEC_WIDTH  LFSR seed; latched at start
test_vector  output  VEC_WIDTH  vector driven to fault detector
vector_valid  output  1  high for the single APPLY cycle of each vector
fault_detected  input  1  detector response
busy  output  1  high in APPLY/WAIT/SAMPLE
done  output  1  run completed normally; sticky until next accepted start
fault_count  output  CNT_WIDTH  vectors that produced a fault (saturating)
first_fail_idx  output  CNT_WIDTH  index of first faulting vector
first_fail_valid  output  1  first_fail_idx is meaningful

Behaviour:
- One clock clk; reset_n is asynchronous, active-low. On reset all outputs are 0, state = IDLE, internal idx and wait counters are 0.
- States: IDLE, APPLY, WAIT, SAMPLE. All outputs are registered.
- IDLE: start=1 and abort=0 -> latch mode; load vector (mode 0: 0; mode 1: seed, or 0x01 if seed==0); idx=0; clear fault_count, first_fail_idx, first_fail_valid and done; go to APPLY.
- APPLY (1 cycle): vector_valid=1, test_vector stable. Go to WAIT if RESP_LATENCY>1, else to SAMPLE.
- WAIT: lasts RESP_LATENCY-1 cycles, then go to SAMPLE. test_vector is held.
- SAMPLE (1 cycle, cycle APPLY+RESP_LATENCY): sample fault_detected.
  - If it is 1: fault_count+1, saturating at 2^CNT_WIDTH-1. If first_fail_valid==0, set first_fail_idx=idx and first_fail_valid=1.
  - If idx==NUM_VECTORS-1: go to IDLE and set done=1 (visible the cycle after SAMPLE).
  - Otherwise: advance vector, idx+1, go to APPLY.
- Vector period = RESP_LATENCY+1 cycles. Run length from accept edge to done: NUM_VECTORS*(RESP_LATENCY+1)+1 edges.
- Vector advance:
  - Mode 0: +1 modulo 2^VEC_WIDTH.
  - Mode 1: Fibonacci shift left; new bit0 = v[7]^v[5]^v[4]^v[3] (x^8+x^6+x^5+x^4+1); the all-zero state is never entered.
- abort (highest priority): in any busy state, go to IDLE next edge; vector_valid=0, done stays 0, partial results are retained. In IDLE, abort masks a simultaneous start.
- start while busy is ignored, with no effect on the run. mode and seed changes mid-run are ignored.
- test_vector holds its last value in IDLE. The vector_valid cycle in SAMPLE->APPLY transitions follows back-to-back with no bubble.
- reset_n asserted mid-run: immediate return to reset values, and no done.

Test Plan:
- Detector faults when test_vector[3]==1; mode 0, NUM_VECTORS=16, RESP_LATENCY=1; start pulse at cycle 0 -> vectors 0x00..0x0F on 16 vector_valid pulses 2 cycles apart; done rises at cycle 33; fault_count=8, first_fail_idx=8, first_fail_valid=1.
- Same detector, mode 1, seed 0x01 -> vectors 0x01,0x02,0x04,0x08,0x11,...; first_fail_idx=3; fault_count matches a reference LFSR model. Seed 0x00 -> first vector 0x01.
- Detector never faults, RESP_LATENCY=3 -> vector_valid pulses every 4 cycles; done at cycle 65; fault_count=0, first_fail_valid=0.
- abort asserted after vector 5's SAMPLE -> IDLE next edge; done=0; fault_count retains its partial value. Re-start -> results cleared and a full run completes.
- start re-pulsed during busy -> ignored, result identical to an undisturbed run. start+abort together in IDLE -> stays IDLE.
- reset_n pulled low for 1 cycle at cycle 10 of a run -> all outputs 0 immediately (asynchronously); no activity until a new start.
